// File: rtl/mem_stage_cached_if.sv
// SRAM controller bus for the cached MEM stage.
// The stage (master) issues 64-bit line-fill reads and single-word writes.
// The SRAM controller (slave) returns the line and a one-cycle completion pulse.
//   sram_rd_en  : line-fill request, held until sram_ready
//   sram_wr_en  : word write request, held until sram_ready
//   sram_addr   : offset address (base already removed)
//   sram_wdata  : store data
//   sram_rdata  : fill line {word1, word0}
//   sram_ready  : completion pulse
interface mem_stage_cached_if;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  modport master (
    output sram_rd_en, sram_wr_en, sram_addr, sram_wdata,
    input  sram_rdata, sram_ready
  );

  modport slave (
    input  sram_rd_en, sram_wr_en, sram_addr, sram_wdata,
    output sram_rdata, sram_ready
  );
endinterface

// File: rtl/mem_stage_cached.sv
// MEM stage with an integrated WAYS-way, 2^SET_BITS-set read cache.
// Lines are 64 bits (two words). Stores write through and do not allocate.
// ready=0 freezes the pipeline; the pipeline holds its inputs stable meanwhile.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wb_en_in .. dest_in      pipeline inputs from EXE
//   flush                    invalidate whole cache (honoured only when idle)
//   wb_en, mem_r_en,
//   alu_res, dest            combinational pass-through to WB
//   mem_out, ready           load data and stage-done flag
//   hit_count, miss_count    saturating load hit/miss counters
//   sram                     SRAM controller bus (master side)
module mem_stage_cached #(
  parameter int          SET_BITS  = 6,
  parameter int          WAYS      = 2,
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] val_rm,
  input  logic [3:0]  dest_in,
  input  logic        flush,
  output logic        wb_en,
  output logic        mem_r_en,
  output logic [31:0] alu_res,
  output logic [3:0]  dest,
  output logic [31:0] mem_out,
  output logic        ready,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  mem_stage_cached_if.master sram
);
  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = 29 - SET_BITS;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t state_q, state_d;

  logic [63:0]       line_q  [WAYS][SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [31:0]       hit_cnt_q, miss_cnt_q;

  logic [31:0]         addr_a;
  logic                word_sel;
  logic [SET_BITS-1:0] set_idx;
  logic [TAG_W-1:0]    tag;
  logic                hit, found_inv;
  logic [WAY_W-1:0]    hit_way, victim;
  logic [63:0]         hit_line;
  logic [31:0]         hit_word;
  logic                fill_we, write_upd, flush_clr, hit_inc, miss_inc;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [WAY_W-1:0] rr_next(input logic [WAY_W-1:0] p);
    // WAYS is a power of two, so natural wrap of WAY_W bits is mod WAYS.
    if (WAYS == 1) return '0;
    return p + 1'b1;
  endfunction

  assign wb_en    = wb_en_in;
  assign mem_r_en = mem_r_en_in;
  assign alu_res  = alu_res_in;
  assign dest     = dest_in;

  assign addr_a   = alu_res_in - BASE_ADDR;
  assign word_sel = addr_a[2];
  assign set_idx  = addr_a[SET_BITS+2:3];
  assign tag      = addr_a[31:SET_BITS+3];

  // Lookup and victim choice: first matching way; first invalid way, else round-robin.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    victim    = rr_q[set_idx];
    found_inv = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[set_idx][w] && tag_q[w][set_idx] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!found_inv && !valid_q[set_idx][w]) begin
        found_inv = 1'b1;
        victim    = WAY_W'(w);
      end
    end
  end

  assign hit_line = line_q[hit_way][set_idx];
  assign hit_word = word_sel ? hit_line[63:32] : hit_line[31:0];

  always_comb begin
    state_d         = state_q;
    ready           = 1'b0;
    mem_out         = '0;
    sram.sram_rd_en = 1'b0;
    sram.sram_wr_en = 1'b0;
    sram.sram_addr  = '0;
    sram.sram_wdata = '0;
    fill_we         = 1'b0;
    write_upd       = 1'b0;
    flush_clr       = 1'b0;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush) begin
          // Flush wins; the held request is served on the following cycle.
          flush_clr = 1'b1;
        end else if (mem_w_en_in) begin
          write_upd = hit;
          state_d   = WRITE;
        end else if (mem_r_en_in) begin
          if (hit) begin
            ready   = 1'b1;
            mem_out = hit_word;
            hit_inc = 1'b1;
          end else begin
            state_d = FILL;
          end
        end else begin
          ready = 1'b1;
        end
      end
      FILL: begin
        sram.sram_rd_en = 1'b1;
        sram.sram_addr  = {addr_a[31:3], 3'b000};
        if (sram.sram_ready) begin
          ready    = 1'b1;
          mem_out  = word_sel ? sram.sram_rdata[63:32] : sram.sram_rdata[31:0];
          fill_we  = 1'b1;
          miss_inc = 1'b1;
          state_d  = IDLE;
        end
      end
      WRITE: begin
        sram.sram_wr_en = 1'b1;
        sram.sram_addr  = addr_a;
        sram.sram_wdata = val_rm;
        if (sram.sram_ready) begin
          ready   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q <= state_d;
      if (flush_clr) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end
      if (fill_we) begin
        valid_q[set_idx][victim] <= 1'b1;
        rr_q[set_idx]            <= rr_next(rr_q[set_idx]);
      end
      if (hit_inc)  hit_cnt_q  <= sat_inc(hit_cnt_q);
      if (miss_inc) miss_cnt_q <= sat_inc(miss_cnt_q);
    end
  end

  // Line data and tags carry no reset; valid bits alone decide whether they are used.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      line_q[victim][set_idx] <= sram.sram_rdata;
      tag_q[victim][set_idx]  <= tag;
    end
    if (write_upd) begin
      if (word_sel) line_q[hit_way][set_idx][63:32] <= val_rm;
      else          line_q[hit_way][set_idx][31:0]  <= val_rm;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
endmodule
